// File: rtl/iter_alu.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic/arith/shift ops,
// iterative shift-add multiply and, when ALU_DIV_EN is defined, restoring unsigned divide/remainder.
module iter_alu #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH),
    localparam int CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;   // multiplicand, or divisor during DIV
    logic [WIDTH-1:0] mplier;  // multiplier, or dividend/quotient shift register during DIV
    logic [WIDTH-1:0] acc;     // product accumulator, or partial remainder during DIV
    logic [3:0]       op;
    logic             is_mul, is_div;

    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] fop,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] sx, sy;
        logic [SHAMT_W-1:0]      sh;
        sx = x;
        sy = y;
        sh = y[SHAMT_W-1:0];
        case (fop)
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return {{(WIDTH-1){1'b0}}, sx < sy};
            4'd5:    return {{(WIDTH-1){1'b0}}, x < y};
            4'd6:    return x ^ y;
            4'd7:    return ~(x | y);
            4'd8:    return x << sh;
            4'd9:    return x >> sh;
            4'd10:   return WIDTH'(sx >>> sh);
            default: return x + y;
        endcase
    endfunction

    function automatic logic ovf_of(input logic [3:0] fop,
                                    input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] r);
        case (fop)
            4'd1:    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
                     return 1'b0;
            default: return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        endcase
    endfunction

    assign is_mul = (aluop == 4'd11);
`ifdef ALU_DIV_EN
    assign is_div = (aluop == 4'd12) || (aluop == 4'd13);

    // Trial subtraction of the divisor from the remainder with the next dividend bit shifted in.
    logic [WIDTH:0] trial;
    assign trial = {acc, mplier[WIDTH-1]} - {1'b0, mcand};
`else
    assign is_div = 1'b0;
`endif

    assign busy = (state == MUL) || (state == DIV);
    assign zero = (c == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
                if (is_mul)      state_nxt = MUL;
                else if (is_div) state_nxt = DIV;
            end
            MUL, DIV: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            op     <= '0;
            c      <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op <= aluop;
                    if (is_mul) begin
                        cnt    <= CNT_W'(WIDTH);
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                    end else if (is_div) begin
                        cnt    <= CNT_W'(WIDTH);
                        mcand  <= b;
                        mplier <= a;
                        acc    <= '0;
                    end else begin
                        c    <= alu_single(aluop, a, b);
                        ovf  <= ovf_of(aluop, a, b, alu_single(aluop, a, b));
                        done <= 1'b1;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                end
                DIV: begin
`ifdef ALU_DIV_EN
                    // A zero divisor always passes the trial, giving all-ones quotient and remainder = a.
                    if (!trial[WIDTH]) begin
                        acc    <= trial[WIDTH-1:0];
                        mplier <= {mplier[WIDTH-2:0], 1'b1};
                    end else begin
                        acc    <= {acc[WIDTH-2:0], mplier[WIDTH-1]};
                        mplier <= {mplier[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
`endif
                end
                DONE: begin
                    c    <= (op == 4'd12) ? mplier : acc;
                    ovf  <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (WIDTH=32); DIVU/REMU expectations follow ALU_DIV_EN.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  aluop;
    logic [31:0] a, b;
    logic        busy, done, zero, ovf;
    logic [31:0] c;

    int checks   = 0;
    int failures = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle op: result and done must appear right after the accept edge.
    task automatic op1(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_c, input logic exp_ovf, input string tag);
        @(negedge clk);
        start = 1'b1; aluop = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_c"}, c, exp_c);
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    // Multi-cycle op: done must arrive WIDTH+1 edges after the accept edge.
    task automatic mc_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_c, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; aluop = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_c"}, c, exp_c);
    endtask

    initial begin
        int n, busycnt;
        logic [31:0] c_before;
        logic changed, overlap;

        rst_n = 1'b0; start = 1'b0; aluop = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // Abort a MUL with an asynchronous reset.
        op1(4'd0, 32'd9, 32'd9, 32'd18, 1'b0, "add9");
        @(negedge clk);
        start = 1'b1; aluop = 4'd11; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_c", c, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        @(negedge clk) rst_n = 1'b1;

        op1(4'd0, 32'd3, 32'd4, 32'd7, 1'b0, "add34");
        chk("add34_zero", {31'd0, zero}, 32'd0);
        @(posedge clk); #1;
        chk("add34_pulse", {31'd0, done}, 32'd0);
        chk("add34_hold", c, 32'd7);

        op1(4'd0,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, "add_ovf");
        op1(4'd1,  32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, "sub57");
        op1(4'd1,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, "sub_ovf");
        op1(4'd4,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt");
        op1(4'd5,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "sltu");
        chk("sltu_zero", {31'd0, zero}, 32'd1);
        op1(4'd7,  32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, "nor");
        op1(4'd6,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, "xor");
        op1(4'd8,  32'd1, 32'h24, 32'h10, 1'b0, "sll");
        op1(4'd9,  32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, "srl");
        op1(4'd10, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, "sra");
        op1(4'd14, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, "op14");
        op1(4'd15, 32'd10, 32'd20, 32'd30, 1'b0, "op15");

        // MUL -3*7 with an ignored start while busy.
        op1(4'd3, 32'h0000_1200, 32'h0000_0034, 32'h0000_1234, 1'b0, "or_pre");
        c_before = 32'h0000_1234;
        @(negedge clk);
        start = 1'b1; aluop = 4'd11; a = 32'hFFFF_FFFD; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mul_busy0", {31'd0, busy}, 32'd1);
        chk("mul_done0", {31'd0, done}, 32'd0);
        busycnt = busy ? 1 : 0;
        n = 0; changed = 1'b0; overlap = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (busy) busycnt++;
            if (busy && done) overlap = 1'b1;
            if (!done && c !== c_before) changed = 1'b1;
            if (n == 2) begin start = 1'b1; aluop = 4'd0; a = 32'd1; b = 32'd1; end
            if (n == 6) start = 1'b0;
        end
        chk("mul_lat", n, 33);
        chk("mul_busycnt", busycnt, 32);
        chk("mul_c", c, 32'hFFFF_FFEB);
        chk("mul_hold", {31'd0, changed}, 32'd0);
        chk("mul_overlap", {31'd0, overlap}, 32'd0);
        @(posedge clk); #1;
        chk("mul_pulse", {31'd0, done}, 32'd0);
        chk("mul_noqueue", {31'd0, busy}, 32'd0);
        chk("mul_c_held", c, 32'hFFFF_FFEB);

        mc_op(4'd11, 32'h0001_0000, 32'h0001_0000, 32'd0, "mul_wrap");
        chk("mul_wrap_zero", {31'd0, zero}, 32'd1);

`ifdef ALU_DIV_EN
        mc_op(4'd12, 32'd100, 32'd7, 32'd14, "divu");
        mc_op(4'd13, 32'd100, 32'd7, 32'd2, "remu");
        mc_op(4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu0");
        mc_op(4'd13, 32'd5, 32'd0, 32'd5, "remu0");
`else
        op1(4'd12, 32'd100, 32'd7, 32'd107, 1'b0, "divu_add");
        op1(4'd13, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, "remu_add");
`endif

        // Back-to-back single-cycle ops on consecutive edges.
        @(negedge clk);
        start = 1'b1; aluop = 4'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        chk("b2b_add_done", {31'd0, done}, 32'd1);
        chk("b2b_add_c", c, 32'd7);
        aluop = 4'd2; a = 32'h0000_F0F0; b = 32'h0000_FF00;
        @(posedge clk); #1;
        chk("b2b_and_done", {31'd0, done}, 32'd1);
        chk("b2b_and_c", c, 32'h0000_F000);
        aluop = 4'd3; a = 32'h0000_F0F0; b = 32'h0000_0F0F;
        @(posedge clk); #1;
        chk("b2b_or_done", {31'd0, done}, 32'd1);
        chk("b2b_or_c", c, 32'h0000_FFFF);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end_done", {31'd0, done}, 32'd0);
        chk("b2b_end_c", c, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
